// File: rtl/slot_c8_arbiter.sv
// Tracks which virtual slot owns the shared $C800-$CFFF expansion ROM window and
// produces the gated expansion-ROM strobe, sampling the bus once per phi0 high phase.
`timescale 1ns/1ps
module slot_c8_arbiter #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic        clk_logic,
    input  logic        system_reset,
    input  logic        phi0,
    input  logic [15:0] addr,
    input  logic        m2sel_n,
    input  logic [2:0]  slot,
    input  logic [7:0]  card_id,
    input  logic        ioselect_n,
    input  logic        intcxrom,
    input  logic        intc8rom,
    input  logic        cfg_wr,
    input  logic [2:0]  cfg_slot,
    input  logic [7:0]  cfg_card_i,
    output logic        c8_valid,
    output logic [2:0]  c8_owner,
    output logic [7:0]  c8_card_id,
    output logic        c8_sample,
    output logic        c8_select_n
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE_CYCLES);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        phi0_q;
    logic        wait_low_q, wait_low_d;
    logic        valid_q, valid_d;
    logic [2:0]  owner_q, owner_d;
    logic [7:0]  card_q, card_d;

    logic        rise;
    logic        sample;
    logic        release_hit;
    logic        claim_hit;
    logic        unused_cfg_card;

    // Any reconfiguration of the owning slot revokes ownership; the new ID itself is irrelevant.
    assign unused_cfg_card = ^cfg_card_i;

    // After a reset taken with phi0 high, the rest of that phase must not look like a rise.
    assign wait_low_d = wait_low_q & phi0;
    assign rise       = phi0 & ~phi0_q & ~wait_low_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sample  = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = SETTLE;
                    cnt_d   = 4'd1;
                end
            end
            SETTLE: begin
                if (!phi0) begin
                    state_d = IDLE;
                end else if (cnt_q == SETTLE_CNT) begin
                    sample  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                if (!phi0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign release_hit = ~m2sel_n & (addr == 16'hCFFF);
    assign claim_hit   = ~ioselect_n & (card_id != 8'd0) & (slot != 3'd0)
                       & ~(cfg_wr & (cfg_slot == slot));

    always_comb begin
        valid_d = valid_q;
        owner_d = owner_q;
        card_d  = card_q;
        if (cfg_wr && valid_q && (cfg_slot == owner_q)) begin
            valid_d = 1'b0;
        end
        if (sample) begin
            if (release_hit) begin
                valid_d = 1'b0;
            end
            if (claim_hit) begin
                valid_d = 1'b1;
                owner_d = slot;
                card_d  = card_id;
            end
        end
    end

    always_ff @(posedge clk_logic) begin
        if (system_reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            phi0_q     <= 1'b0;
            wait_low_q <= phi0;
            valid_q    <= 1'b0;
            owner_q    <= 3'd0;
            card_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            phi0_q     <= phi0;
            wait_low_q <= wait_low_d;
            valid_q    <= valid_d;
            owner_q    <= owner_d;
            card_q     <= card_d;
        end
    end

    assign c8_valid    = valid_q;
    assign c8_owner    = owner_q;
    assign c8_card_id  = card_q;
    assign c8_sample   = sample & ~system_reset;
    assign c8_select_n = ~(phi0 & valid_q & ~m2sel_n & (addr[15:11] == 5'b11001)
                           & ~intcxrom & ~intc8rom);

endmodule

// File: tb/tb_slot_c8_arbiter.sv
// Bench for slot_c8_arbiter: directed scenarios plus randomized traffic against a
// phase-position reference model of window ownership.
`timescale 1ns/1ps
module tb_slot_c8_arbiter;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        phi0 = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic        m2sel_n = 1'b1;
    logic [2:0]  slot = 3'd0;
    logic [7:0]  card_id = 8'd0;
    logic        ioselect_n = 1'b1;
    logic        intcxrom = 1'b0;
    logic        intc8rom = 1'b0;
    logic        cfg_wr = 1'b0;
    logic [2:0]  cfg_slot = 3'd0;
    logic [7:0]  cfg_card = 8'd0;
    logic        c8_valid;
    logic [2:0]  c8_owner;
    logic [7:0]  c8_card_id;
    logic        c8_sample;
    logic        c8_select_n;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    slot_c8_arbiter #(.SETTLE_CYCLES(S)) dut (
        .clk_logic   (clk),
        .system_reset(rst),
        .phi0        (phi0),
        .addr        (addr),
        .m2sel_n     (m2sel_n),
        .slot        (slot),
        .card_id     (card_id),
        .ioselect_n  (ioselect_n),
        .intcxrom    (intcxrom),
        .intc8rom    (intc8rom),
        .cfg_wr      (cfg_wr),
        .cfg_slot    (cfg_slot),
        .cfg_card_i  (cfg_card),
        .c8_valid    (c8_valid),
        .c8_owner    (c8_owner),
        .c8_card_id  (c8_card_id),
        .c8_sample   (c8_sample),
        .c8_select_n (c8_select_n)
    );

    // Reference model: position of the current cycle within its phi0 high run
    // (rise cycle = 0); the phase samples at position S unless a reset spoiled it.
    bit         m_last_phi0 = 1'b0;
    int         m_last_pos  = 0;
    bit         m_ok_carry  = 1'b0;
    bit         m_valid     = 1'b0;
    logic [2:0] m_owner     = 3'd0;
    logic [7:0] m_card      = 8'd0;
    int         cur_pos;
    bit         cur_ok;
    bit         exp_sample;
    bit         exp_sel_n;
    bit         m_nv;
    logic [2:0] m_no;
    logic [7:0] m_nc;

    always_comb begin
        cur_pos    = m_last_phi0 ? m_last_pos + 1 : 0;
        cur_ok     = m_last_phi0 ? m_ok_carry : 1'b1;
        exp_sample = !rst && phi0 && cur_ok && (cur_pos == S);
        exp_sel_n  = !(phi0 && m_valid && !m2sel_n && (addr >= 16'hC800) && (addr <= 16'hCFFF)
                       && !intcxrom && !intc8rom);
        m_nv = m_valid;
        m_no = m_owner;
        m_nc = m_card;
        if (cfg_wr && m_valid && cfg_slot == m_owner) m_nv = 1'b0;
        if (exp_sample) begin
            if (!m2sel_n && addr == 16'hCFFF) m_nv = 1'b0;
            if (!ioselect_n && card_id != 8'd0 && slot != 3'd0 && !(cfg_wr && cfg_slot == slot)) begin
                m_nv = 1'b1;
                m_no = slot;
                m_nc = card_id;
            end
        end
    end

    always @(posedge clk) begin
        m_last_phi0 <= phi0;
        m_last_pos  <= cur_pos;
        m_ok_carry  <= rst ? 1'b0 : cur_ok;
        m_valid     <= rst ? 1'b0 : m_nv;
        m_owner     <= rst ? 3'd0 : m_no;
        m_card      <= rst ? 8'd0 : m_nc;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout reached");
        $fatal(1, "watchdog");
    end

    task automatic set_bus(input logic [15:0] a, input logic ios_n, input logic [2:0] sl,
                           input logic [7:0] cid, input logic m2);
        addr = a; ioselect_n = ios_n; slot = sl; card_id = cid; m2sel_n = m2;
    endtask

    // Drives hi cycles of phi0 high then lo cycles low, optionally pulsing cfg_wr or
    // reset at a given position, and reports what was observed.
    task automatic run_phase(input int hi, input int lo, input int cfg_at, input logic [2:0] cs,
                             input int rst_at, output int ns, output int sat,
                             output bit all_low, output bit any_low, output bit v_after);
        ns = 0; sat = -1; all_low = 1'b1; any_low = 1'b0; v_after = 1'b0;
        for (int i = 0; i < hi + lo; i++) begin
            @(posedge clk); #1;
            phi0     = (i < hi);
            cfg_wr   = (i == cfg_at);
            cfg_slot = cs;
            rst      = (i == rst_at);
            @(negedge clk);
            if (sat >= 0 && i == sat + 1) v_after = c8_valid;
            if (c8_sample === 1'b1) begin ns++; sat = i; end
            if (i < hi) begin
                if (c8_select_n !== 1'b0) all_low = 1'b0;
                if (c8_select_n === 1'b0) any_low = 1'b1;
            end
        end
        cfg_wr = 1'b0;
        rst    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_chk++; if (c8_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", c8_valid); else n_pass++;
        n_chk++; if (c8_owner !== 3'd0) $display("FAIL reset_owner got %0d want 0", c8_owner); else n_pass++;
        n_chk++; if (c8_card_id !== 8'd0) $display("FAIL reset_card got %h want 00", c8_card_id); else n_pass++;
        n_chk++; if (c8_sample !== 1'b0) $display("FAIL reset_sample got %b want 0", c8_sample); else n_pass++;
        n_chk++; if (c8_select_n !== 1'b1) $display("FAIL reset_select_n got %b want 1", c8_select_n); else n_pass++;
    endtask

    task automatic test_claim();
        int ns, sat; bit al, an, va;
        set_bus(16'hC600, 1'b0, 3'd6, 8'h02, 1'b0);
        run_phase(10, 2, -1, 3'd0, -1, ns, sat, al, an, va);
        n_chk++; if (ns !== 1) $display("FAIL claim_nsamp got %0d want 1", ns); else n_pass++;
        n_chk++; if (sat !== S) $display("FAIL claim_samp_pos got %0d want %0d", sat, S); else n_pass++;
        n_chk++; if (va !== 1'b1) $display("FAIL claim_valid_next got %b want 1", va); else n_pass++;
        n_chk++; if (c8_owner !== 3'd6) $display("FAIL claim_owner got %0d want 6", c8_owner); else n_pass++;
        n_chk++; if (c8_card_id !== 8'h02) $display("FAIL claim_card got %h want 02", c8_card_id); else n_pass++;
    endtask

    task automatic test_strobe_release();
        int ns, sat; bit al, an, va;
        set_bus(16'hC900, 1'b1, 3'd6, 8'h02, 1'b0);
        run_phase(10, 2, -1, 3'd0, -1, ns, sat, al, an, va);
        n_chk++; if (al !== 1'b1) $display("FAIL strobe_c900_low got %b want 1", al); else n_pass++;
        n_chk++; if (c8_valid !== 1'b1) $display("FAIL strobe_keep_valid got %b want 1", c8_valid); else n_pass++;
        set_bus(16'hCFFF, 1'b1, 3'd6, 8'h02, 1'b0);
        run_phase(S + 1, 0, -1, 3'd0, -1, ns, sat, al, an, va);
        n_chk++; if (al !== 1'b1) $display("FAIL strobe_cfff_low got %b want 1", al); else n_pass++;
        n_chk++; if (sat !== S) $display("FAIL release_samp_pos got %0d want %0d", sat, S); else n_pass++;
        @(posedge clk); #1;
        @(negedge clk);
        n_chk++; if (c8_valid !== 1'b0) $display("FAIL release_valid got %b want 0", c8_valid); else n_pass++;
        n_chk++; if (c8_select_n !== 1'b1) $display("FAIL release_select_n got %b want 1", c8_select_n); else n_pass++;
        n_chk++; if (c8_owner !== 3'd6) $display("FAIL release_owner_hold got %0d want 6", c8_owner); else n_pass++;
        run_phase(0, 2, -1, 3'd0, -1, ns, sat, al, an, va);
        set_bus(16'hC900, 1'b1, 3'd6, 8'h02, 1'b0);
        run_phase(10, 2, -1, 3'd0, -1, ns, sat, al, an, va);
        n_chk++; if (an !== 1'b0) $display("FAIL post_release_strobe got %b want 0", an); else n_pass++;
    endtask

    task automatic test_runt();
        int ns, sat; bit al, an, va;
        set_bus(16'hC600, 1'b0, 3'd6, 8'h02, 1'b0);
        run_phase(2, 3, -1, 3'd0, -1, ns, sat, al, an, va);
        n_chk++; if (ns !== 0) $display("FAIL runt_nsamp got %0d want 0", ns); else n_pass++;
        n_chk++; if (c8_valid !== 1'b0) $display("FAIL runt_valid got %b want 0", c8_valid); else n_pass++;
        run_phase(10, 2, -1, 3'd0, -1, ns, sat, al, an, va);
        n_chk++; if (ns !== 1) $display("FAIL after_runt_nsamp got %0d want 1", ns); else n_pass++;
        n_chk++; if (c8_valid !== 1'b1) $display("FAIL after_runt_valid got %b want 1", c8_valid); else n_pass++;
    endtask

    task automatic test_cfg_collision();
        int ns, sat; bit al, an, va;
        set_bus(16'hC400, 1'b0, 3'd4, 8'h11, 1'b0);
        run_phase(10, 2, -1, 3'd0, -1, ns, sat, al, an, va);
        n_chk++; if (c8_owner !== 3'd4) $display("FAIL cfg_setup_owner got %0d want 4", c8_owner); else n_pass++;
        @(posedge clk); #1;
        cfg_wr = 1'b1; cfg_slot = 3'd4; cfg_card = 8'h00;
        @(posedge clk); #1;
        cfg_wr = 1'b0;
        @(negedge clk);
        n_chk++; if (c8_valid !== 1'b0) $display("FAIL cfg_revoke_valid got %b want 0", c8_valid); else n_pass++;
        set_bus(16'hC500, 1'b0, 3'd5, 8'h22, 1'b0);
        run_phase(10, 2, S, 3'd5, -1, ns, sat, al, an, va);
        n_chk++; if (ns !== 1) $display("FAIL cfg_same_nsamp got %0d want 1", ns); else n_pass++;
        n_chk++; if (c8_valid !== 1'b0) $display("FAIL cfg_same_slot_claim got %b want 0", c8_valid); else n_pass++;
        set_bus(16'hC300, 1'b0, 3'd3, 8'h33, 1'b0);
        run_phase(10, 2, S, 3'd5, -1, ns, sat, al, an, va);
        n_chk++; if (c8_valid !== 1'b1) $display("FAIL cfg_other_slot_valid got %b want 1", c8_valid); else n_pass++;
        n_chk++; if (c8_owner !== 3'd3) $display("FAIL cfg_other_slot_owner got %0d want 3", c8_owner); else n_pass++;
        set_bus(16'hC300, 1'b0, 3'd3, 8'h44, 1'b0);
        run_phase(10, 2, S, 3'd3, -1, ns, sat, al, an, va);
        n_chk++; if (c8_valid !== 1'b0) $display("FAIL cfg_owner_reclaim got %b want 0", c8_valid); else n_pass++;
    endtask

    task automatic test_introm();
        int ns, sat; bit al, an, va;
        set_bus(16'hC200, 1'b0, 3'd2, 8'h05, 1'b0);
        run_phase(10, 2, -1, 3'd0, -1, ns, sat, al, an, va);
        set_bus(16'hC800, 1'b1, 3'd2, 8'h05, 1'b0);
        intc8rom = 1'b1;
        run_phase(6, 1, -1, 3'd0, -1, ns, sat, al, an, va);
        n_chk++; if (an !== 1'b0) $display("FAIL intc8rom_strobe got %b want 0", an); else n_pass++;
        n_chk++; if (c8_valid !== 1'b1) $display("FAIL intc8rom_valid got %b want 1", c8_valid); else n_pass++;
        intc8rom = 1'b0; intcxrom = 1'b1;
        run_phase(6, 1, -1, 3'd0, -1, ns, sat, al, an, va);
        n_chk++; if (an !== 1'b0) $display("FAIL intcxrom_strobe got %b want 0", an); else n_pass++;
        intcxrom = 1'b0;
        run_phase(6, 1, -1, 3'd0, -1, ns, sat, al, an, va);
        n_chk++; if (al !== 1'b1) $display("FAIL introm_off_strobe got %b want 1", al); else n_pass++;
    endtask

    task automatic test_reset_mid_phase();
        int ns, sat; bit al, an, va;
        set_bus(16'hC700, 1'b0, 3'd7, 8'h09, 1'b0);
        run_phase(10, 2, -1, 3'd0, 2, ns, sat, al, an, va);
        n_chk++; if (ns !== 0) $display("FAIL rstmid_nsamp got %0d want 0", ns); else n_pass++;
        n_chk++; if (c8_valid !== 1'b0) $display("FAIL rstmid_valid got %b want 0", c8_valid); else n_pass++;
        n_chk++; if (c8_owner !== 3'd0) $display("FAIL rstmid_owner got %0d want 0", c8_owner); else n_pass++;
        n_chk++; if (c8_card_id !== 8'd0) $display("FAIL rstmid_card got %h want 00", c8_card_id); else n_pass++;
        run_phase(10, 2, -1, 3'd0, -1, ns, sat, al, an, va);
        n_chk++; if (ns !== 1) $display("FAIL rstmid_next_nsamp got %0d want 1", ns); else n_pass++;
        n_chk++; if (c8_owner !== 3'd7) $display("FAIL rstmid_next_owner got %0d want 7", c8_owner); else n_pass++;
        n_chk++; if (c8_card_id !== 8'h09) $display("FAIL rstmid_next_card got %h want 09", c8_card_id); else n_pass++;
    endtask

    task automatic test_random();
        int rem = 0;
        logic [2:0] r3;
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            if (rem == 0) begin
                phi0 = ~phi0;
                rem  = phi0 ? int'($urandom_range(1, 9)) : int'($urandom_range(1, 4));
            end
            rem--;
            if ($urandom_range(0, 2) == 0) begin
                r3 = 3'($urandom_range(0, 7));
                case ($urandom_range(0, 3))
                    0: addr = 16'hC000 | {5'd0, r3, 8'd0};
                    1: addr = 16'hCFFF;
                    2: addr = 16'hC800 + 16'($urandom_range(0, 2047));
                    default: addr = 16'($urandom);
                endcase
                slot       = 3'($urandom_range(0, 7));
                card_id    = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
                ioselect_n = 1'($urandom_range(0, 1));
                m2sel_n    = ($urandom_range(0, 3) == 0);
            end
            intcxrom = ($urandom_range(0, 7) == 0);
            intc8rom = ($urandom_range(0, 7) == 0);
            cfg_wr   = ($urandom_range(0, 15) == 0);
            cfg_slot = 3'($urandom_range(0, 7));
            cfg_card = 8'($urandom);
            rst      = ($urandom_range(0, 199) == 0);
            @(negedge clk);
            n_chk++; if (c8_sample !== exp_sample) $display("FAIL rand_sample cyc %0d got %b want %b", n, c8_sample, exp_sample); else n_pass++;
            n_chk++; if (c8_select_n !== exp_sel_n) $display("FAIL rand_select_n cyc %0d got %b want %b", n, c8_select_n, exp_sel_n); else n_pass++;
            n_chk++; if (c8_valid !== m_valid) $display("FAIL rand_valid cyc %0d got %b want %b", n, c8_valid, m_valid); else n_pass++;
            n_chk++; if (c8_owner !== m_owner) $display("FAIL rand_owner cyc %0d got %0d want %0d", n, c8_owner, m_owner); else n_pass++;
            n_chk++; if (c8_card_id !== m_card) $display("FAIL rand_card cyc %0d got %h want %h", n, c8_card_id, m_card); else n_pass++;
        end
        rst = 1'b0; cfg_wr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_claim();
        test_strobe_release();
        test_runt();
        test_cfg_collision();
        test_introm();
        test_reset_mid_phase();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/slot_c8_arbiter.md
Name: slot_c8_arbiter

Overview:
- Sits downstream of the virtual slot controller and consumes its per-access slot select outputs.
- Tracks which virtual slot currently owns the shared $C800-$CFFF expansion ROM window, following Apple II semantics:
  - a card claims the window on an access to its $Cn00 page;
  - all cards release it on an access to $CFFF.
- Produces the gated expansion-ROM strobe that card models use to respond in $C800-$CFFF.
- Samples the bus exactly once per phi0 high phase, after a settle delay.

Parameters:
SETTLE_CYCLES, 4, clk_logic cycles after the phi0 rising edge before the bus is sampled (1..15)

Ports:
clk_logic  input  1  system logic clock
system_reset  input  1  synchronous, active-high reset
phi0  input  1  bus phase 0, already synchronous to clk_logic
addr  input  16  bus address
m2sel_n  input  1  active-low bus memory select qualifier
slot  input  3  currently selected virtual slot, from the slot controller
card_id  input  8  card ID of the selected slot (0 = empty)
ioselect_n  input  1  active-low $Cn00 page select, from the slot controller
intcxrom  input  1  internal $Cxxx ROM selected
intc8rom  input  1  internal $C800 ROM selected
cfg_wr  input  1  slot configuration write strobe
cfg_slot  input  3  slot being reconfigured
cfg_card_i  input  8  new card ID being written
c8_valid  output  1  the window is owned by a slot
c8_owner  output  3  owning slot number
c8_card_id  output  8  card ID of the owner, latched at claim
c8_sample  output  1  one-cycle pulse when the bus sample is taken
c8_select_n  output  1  active-low gated $C800-$CFFF strobe for the owner

Behaviour:
- Reset: while system_reset is high at a clk_logic edge:
  - c8_valid=0, c8_owner=0, c8_card_id=0, c8_sample=0;
  - FSM goes to IDLE; counter=0; phi0_d=0.
- phi0 edge detect uses a registered phi0_d. A rise is phi0 & !phi0_d.
- FSM states:
  - IDLE: on a rise, counter<=1 and go to SETTLE.
  - SETTLE: if phi0=0, go to IDLE (runt phase, no sample). Else if counter==SETTLE_CYCLES, assert c8_sample for one cycle, evaluate events, go to DONE. Else counter++.
  - DONE: wait for phi0=0, then go to IDLE. Exactly one sample occurs per phi0 high phase.
- Sample timing: the sample evaluates addr, m2sel_n, ioselect_n, slot and card_id on the cycle c8_sample is high. The registered result is visible on the following cycle.
- Release: if !m2sel_n & addr==16'hCFFF, then c8_valid<=0. c8_owner and c8_card_id hold their values.
- Claim: if !ioselect_n & card_id!=0 & slot!=0, then c8_valid<=1, c8_owner<=slot, c8_card_id<=card_id.
  - Release and claim are address-exclusive.
  - Re-claiming by the current owner is a no-op apart from refreshing c8_card_id.
- Config snoop: cfg_wr is evaluated every cycle, independent of the FSM.
  - If cfg_wr & c8_valid & cfg_slot==c8_owner, then c8_valid<=0.
  - If cfg_wr coincides with a claim for the same slot, the claim is dropped: c8_valid stays 0, or is cleared if that slot already owned the window.
  - If cfg_wr coincides with a claim for a different slot, the claim takes effect.
- c8_select_n is combinational and equals ~(phi0 & c8_valid & !m2sel_n & addr[15:11]==5'b11001 & !intcxrom & !intc8rom).
  - It is low across $C800-$CFFF, including $CFFF itself during the releasing phase.
  - It goes high the cycle after the release sample.
- intcxrom/intc8rom only gate c8_select_n. Ownership is preserved while they are set.
- Reset mid-phase: the FSM re-arms in IDLE. No sample occurs until the next phi0 rise, even if phi0 is still high.
- Counter is 4 bits wide. SETTLE_CYCLES=1 samples on the cycle after the rise.

Test Plan:
- Claim:
  - Stimulus: slot=6, card_id=8'h02, ioselect_n=0, addr=16'hC600, phi0 high for 10 cycles.
  - Response: c8_sample pulses once, 4 cycles after the rise. The next cycle shows c8_valid=1, c8_owner=6, c8_card_id=8'h02.
- Strobe and release:
  - Stimulus: with slot 6 owning, a phase at addr=16'hC900, then a phase at 16'hCFFF.
  - Response: c8_select_n=0 during both phases. c8_valid=0 one cycle after the $CFFF sample. c8_select_n stays 1 on a subsequent $C900 phase.
- Runt phase:
  - Stimulus: phi0 high for 2 cycles at addr=16'hC600 with ioselect_n=0.
  - Response: no c8_sample, c8_valid unchanged. The next full phase samples normally.
- Config collision:
  - Stimulus: slot 4 owns the window; cfg_wr=1 with cfg_slot=4, cfg_card_i=0.
  - Response: c8_valid=0 next cycle.
  - Stimulus: cfg_wr for slot 5 on the same cycle as a claim sample for slot 5.
  - Response: c8_valid stays 0.
- Internal ROM gating:
  - Stimulus: slot 2 owns the window; intc8rom=1; access addr=16'hC800.
  - Response: c8_select_n=1 and c8_valid remains 1. With intc8rom=0, c8_select_n=0.
- Reset mid-phase:
  - Stimulus: system_reset asserted for 1 cycle during SETTLE, with phi0 still high.
  - Response: all outputs are 0 and no sample occurs in that phase. A claim on the next phase works.
